// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU command sequencer:
//   - sequencer state encoding
//   - ALU function-code fields (unit select in [3:2], op in [1:0])
//   - fill value of the timeout error byte
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_ERR   = 3'd4
  } seq_state_e;

  // Unit select, cmd_fun[3:2]
  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  // Arithmetic-unit function codes
  localparam logic [3:0] FUN_ADD = {UNIT_ARITH, 2'b00};
  localparam logic [3:0] FUN_SUB = {UNIT_ARITH, 2'b01};
  localparam logic [3:0] FUN_MUL = {UNIT_ARITH, 2'b10};
  localparam logic [3:0] FUN_DIV = {UNIT_ARITH, 2'b11};

  // The error byte is all ones at whatever DATA_W the sequencer uses.
  localparam logic       ERR_FILL_BIT = 1'b1;
  localparam logic [7:0] ERR_BYTE     = {8{ERR_FILL_BIT}};

endpackage

// File: rtl/alu_rsp_serializer.sv
// -----------------------------------------------------------------------------
// alu_rsp_serializer
// Holds one OUT_W result word (or an error flag) and emits it as DATA_W-wide
// bytes, least-significant byte first, over a valid/ready channel.
// Ports:
//   clk, srst          clock, synchronous active-high reset
//   load_word, word    load a result word (starts a NB-byte response)
//   load_err           start a one-byte all-ones error response
//   rsp_ready          consumer accepts the current byte
//   rsp_valid/data     current byte (data is zero while idle)
//   rsp_last           current byte is the final one of the response
//   rsp_err            current byte is the error byte
// -----------------------------------------------------------------------------
module alu_rsp_serializer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load_word,
  input  logic              load_err,
  input  logic [OUT_W-1:0]  word,
  input  logic              rsp_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_err
);

  localparam int NB    = OUT_W / DATA_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  logic [OUT_W-1:0] word_q,   word_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic             active_q, active_d;
  logic             err_q,    err_d;

  logic [DATA_W-1:0] byte_sel [NB];
  logic              is_last;

  for (genvar gi = 0; gi < NB; gi++) begin : g_bytes
    assign byte_sel[gi] = word_q[gi*DATA_W +: DATA_W];
  end

  assign is_last = err_q || (idx_q == IDX_W'(NB - 1));

  always_comb begin
    word_d   = word_q;
    idx_d    = idx_q;
    active_d = active_q;
    err_d    = err_q;
    if (load_word) begin
      word_d   = word;
      idx_d    = '0;
      active_d = 1'b1;
      err_d    = 1'b0;
    end else if (load_err) begin
      idx_d    = '0;
      active_d = 1'b1;
      err_d    = 1'b1;
    end else if (active_q && rsp_ready) begin
      if (is_last) begin
        active_d = 1'b0;
        err_d    = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      word_q   <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      word_q   <= word_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  // Byte and flags are pure functions of the held registers, so they stay
  // stable for as long as the consumer stalls.
  always_comb begin
    rsp_valid = active_q;
    rsp_last  = active_q && is_last;
    rsp_err   = active_q && err_q;
    rsp_data  = '0;
    if (active_q) begin
      rsp_data = err_q ? {DATA_W{ERR_FILL_BIT}} : byte_sel[idx_q];
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Accepts one ALU command (function + two operands) at a time, issues it to the
// registered ALU with a one-cycle enable pulse, waits for alu_out_valid with a
// timeout, and returns the result (or an error byte) serialized byte-wise.
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   cmd_valid/ready, cmd_*      command channel
//   alu_a/b/fun, alu_en         ALU drive (operands held until next command)
//   alu_out, alu_out_valid      ALU result
//   rsp_valid/ready/data/last   response byte channel, rsp_err flags timeout
//   busy                        high whenever not idle
// -----------------------------------------------------------------------------
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int OUT_W   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_fun,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_fun,
  output logic              alu_en,
  input  logic [OUT_W-1:0]  alu_out,
  input  logic              alu_out_valid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic              busy
);

  seq_state_e        state_q, state_d;
  logic [3:0]        fun_q,   fun_d;
  logic [DATA_W-1:0] a_q,     a_d;
  logic [DATA_W-1:0] b_q,     b_d;
  logic [7:0]        cnt_q,   cnt_d;

  logic load_word;
  logic load_err;

  // The command registers feed the ALU directly, so the operands appear in
  // ISSUE and stay put until the next command is accepted.
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_fun = fun_q;

  always_comb begin
    state_d   = state_q;
    fun_d     = fun_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    alu_en    = 1'b0;
    load_word = 1'b0;
    load_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          fun_d   = cmd_fun;
          a_d     = cmd_a;
          b_d     = cmd_b;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        alu_en  = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Valid is checked before the timeout so a result in the final
        // WAIT cycle still counts as success.
        if (alu_out_valid) begin
          load_word = 1'b1;
          state_d   = ST_SEND;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          load_err = 1'b1;
          state_d  = ST_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SEND, ST_ERR: begin
        if (rsp_valid && rsp_ready && rsp_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      fun_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fun_q   <= fun_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  alu_rsp_serializer #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_ser (
    .clk       (CLK),
    .srst      (RST),
    .load_word (load_word),
    .load_err  (load_err),
    .word      (alu_out),
    .rsp_ready (rsp_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .rsp_err   (rsp_err)
  );

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Bench for alu_cmd_sequencer with a behavioural ALU of programmable latency,
// a byte scoreboard, table-driven vectors, hand-written timing sequences and
// randomized traffic with random response backpressure.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

  localparam int DATA_W  = 8;
  localparam int OUT_W   = 16;
  localparam int TIMEOUT = 8;
  localparam int NB      = OUT_W / DATA_W;

  logic              CLK;
  logic              RST;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_fun;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_fun;
  logic              alu_en;
  logic [OUT_W-1:0]  alu_out;
  logic              alu_out_valid;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              rsp_err;
  logic              busy;

  alu_cmd_sequencer #(
    .DATA_W  (DATA_W),
    .OUT_W   (OUT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_fun       (cmd_fun),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_fun       (alu_fun),
    .alu_en        (alu_en),
    .alu_out       (alu_out),
    .alu_out_valid (alu_out_valid),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_last      (rsp_last),
    .rsp_err       (rsp_err),
    .busy          (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- behavioural ALU ----------------
  int          alu_lat     = 1;
  bit          alu_respond = 1'b1;
  int          pend_cnt    = 0;
  logic [15:0] pend_res    = '0;

  function automatic logic [15:0] alu_ref(logic [3:0] f, logic [7:0] a, logic [7:0] b);
    int sa = $signed(a);
    int sb = $signed(b);
    int r;
    case (f)
      4'b0000: r = sa + sb;
      4'b0001: r = sa - sb;
      4'b0010: r = sa * sb;
      4'b0011: r = (sb == 0) ? -1 : sa / sb;
      default: r = int'({a & b, a | b}) ^ int'(f);
    endcase
    return r[15:0];
  endfunction

  initial begin
    alu_out_valid = 1'b0;
    alu_out       = '0;
  end

  // Result appears alu_lat cycles after the cycle in which alu_en is high.
  always @(posedge CLK) begin
    #1;
    alu_out_valid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        alu_out_valid = 1'b1;
        alu_out       = pend_res;
      end
    end
    if (alu_en && alu_respond) begin
      pend_cnt = alu_lat;
      pend_res = alu_ref(alu_fun, alu_a, alu_b);
    end
  end

  // ---------------- response ready driver ----------------
  bit ready_force = 1'b1;
  bit ready_rand  = 1'b0;
  initial rsp_ready = 1'b0;
  always @(posedge CLK) begin
    #2;
    rsp_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       e;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_result(input logic [15:0] r);
    exp_q.push_back('{d: r[7:0],  l: 1'b0, e: 1'b0});
    exp_q.push_back('{d: r[15:8], l: 1'b1, e: 1'b0});
  endtask

  task automatic push_err();
    exp_q.push_back('{d: 8'hFF, l: 1'b1, e: 1'b1});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_cmd(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                          output int t_acc);
    bit done = 1'b0;
    @(posedge CLK); #2;
    cmd_valid = 1'b1;
    cmd_fun   = f;
    cmd_a     = a;
    cmd_b     = b;
    t_acc     = -1;
    for (int k = 0; k < 300 && !done; k++) begin
      if (cmd_ready) begin
        t_acc = cyc;
        done  = 1'b1;
      end
      @(posedge CLK); #2;
    end
    cmd_valid = 1'b0;
    if (!done) check("cmd_accept_timeout", 32'd0, 32'd1);
    else $display("cmd  cycle=%0d fun=%b a=0x%02h b=0x%02h", t_acc, f, a, b);
  endtask

  task automatic wait_rsp(output int c);
    c = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (rsp_valid) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic wait_ready(output int c);
    c = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (cmd_ready) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge CLK);
      if (cmd_ready && exp_q.size() == 0) done = 1'b1;
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_alu_en"},    32'(alu_en),    32'd0);
    check({tag, "_alu_a"},     32'(alu_a),     32'd0);
    check({tag, "_alu_b"},     32'(alu_b),     32'd0);
    check({tag, "_alu_fun"},   32'(alu_fun),   32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    check({tag, "_rsp_last"},  32'(rsp_last),  32'd0);
    check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [3:0]  fun;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
  } vec_t;
  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t, t2, c, c2;
    bit       stall_prev = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;

    vecs[0] = '{4'b0000, 8'h05, 8'h03, 16'h0008};
    vecs[1] = '{4'b0010, 8'h7F, 8'h02, 16'h00FE};
    vecs[2] = '{4'b0001, 8'h03, 8'h05, 16'hFFFE};
    vecs[3] = '{4'b0000, 8'h80, 8'h80, 16'hFF00};
    vecs[4] = '{4'b0010, 8'h80, 8'h80, 16'h4000};
    vecs[5] = '{4'b0010, 8'hFF, 8'h02, 16'hFFFE};
    vecs[6] = '{4'b0011, 8'hF6, 8'h03, 16'hFFFD};
    vecs[7] = '{4'b0000, 8'h7F, 8'h01, 16'h0080};

    RST       = 1'b1;
    cmd_valid = 1'b0;
    cmd_fun   = '0;
    cmd_a     = '0;
    cmd_b     = '0;

    // Byte monitor: scoreboard compare on every handshake, hold check on stall.
    fork
      forever begin
        @(negedge CLK);
        if (stall_prev && !RST) begin
          check("hold_valid", 32'(rsp_valid), 32'd1);
          check("hold_data",  32'(rsp_data),  32'(prev_data));
          check("hold_last",  32'(rsp_last),  32'(prev_last));
        end
        if (rsp_valid && rsp_ready) begin
          $display("rsp  cycle=%0d data=0x%02h last=%0d err=%0d", cyc, rsp_data, rsp_last, rsp_err);
          if (exp_q.size() == 0) begin
            check("unexpected_byte", 32'(rsp_valid), 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rsp_data", 32'(rsp_data), 32'(e.d));
            check("rsp_last", 32'(rsp_last), 32'(e.l));
            check("rsp_err",  32'(rsp_err),  32'(e.e));
          end
        end
        stall_prev = rsp_valid && !rsp_ready && !RST;
        prev_data  = rsp_data;
        prev_last  = rsp_last;
      end
    join_none

    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    check_reset_outputs("reset");

    // ---- ADD with latency checks ----
    alu_lat = 1;
    push_result(16'h0008);
    send_cmd(4'b0000, 8'h05, 8'h03, t);
    @(negedge CLK);
    check("add_en_t1",   32'(alu_en),  32'd1);
    check("add_alu_a",   32'(alu_a),   32'h05);
    check("add_alu_b",   32'(alu_b),   32'h03);
    check("add_alu_fun", 32'(alu_fun), 32'h0);
    @(negedge CLK);
    check("add_en_t2",   32'(alu_en),    32'd0);
    check("add_nrsp_t2", 32'(rsp_valid), 32'd0);
    check("add_busy_t2", 32'(busy),      32'd1);
    wait_rsp(c);
    check("add_first_rsp_cycle", 32'(c), 32'(t + 3));
    wait_ready(c);
    check("add_ready_return", 32'(c), 32'(t + 3 + NB));
    check("add_alu_a_held",   32'(alu_a), 32'h05);
    wait_drain();

    // ---- table vectors ----
    for (int i = 0; i < 8; i++) begin
      push_result(vecs[i].res);
      send_cmd(vecs[i].fun, vecs[i].a, vecs[i].b, t);
    end
    wait_drain();

    // ---- backpressure on byte 0 ----
    ready_force = 1'b0;
    push_result(16'h0008);
    send_cmd(4'b0000, 8'h05, 8'h03, t);
    wait_rsp(c);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("bp_valid",     32'(rsp_valid), 32'd1);
      check("bp_data",      32'(rsp_data),  32'h08);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    ready_force = 1'b1;
    wait_ready(c2);
    check("bp_ready_return", 32'(c2), 32'(c + 8));
    wait_drain();

    // ---- busy blocking: second command held off during WAIT ----
    alu_lat = 4;
    push_result(16'h0008);
    push_result(16'h0013);
    send_cmd(4'b0000, 8'h05, 8'h03, t);
    send_cmd(4'b0000, 8'h10, 8'h03, t2);
    check("busy_second_accept", 32'(t2), 32'(t + 1 + 4 + NB + 1));
    wait_drain();

    // ---- timeout ----
    alu_respond = 1'b0;
    push_err();
    send_cmd(4'b0000, 8'h01, 8'h01, t);
    wait_rsp(c);
    check("to_rsp_cycle", 32'(c), 32'(t + 2 + TIMEOUT));
    check("to_err_flag",  32'(rsp_err),  32'd1);
    check("to_err_last",  32'(rsp_last), 32'd1);
    check("to_err_data",  32'(rsp_data), 32'hFF);
    wait_drain();
    alu_respond = 1'b1;

    // ---- timeout boundary: result in the final WAIT cycle wins ----
    alu_lat = TIMEOUT;
    push_result(16'h0002);
    send_cmd(4'b0000, 8'h01, 8'h01, t);
    wait_rsp(c);
    check("bnd_rsp_cycle", 32'(c), 32'(t + 2 + TIMEOUT));
    check("bnd_no_err",    32'(rsp_err), 32'd0);
    wait_drain();

    // one cycle later is too late
    alu_lat = TIMEOUT + 1;
    push_err();
    send_cmd(4'b0000, 8'h01, 8'h01, t);
    wait_rsp(c);
    check("late_rsp_cycle", 32'(c), 32'(t + 2 + TIMEOUT));
    check("late_err",       32'(rsp_err), 32'd1);
    wait_drain();

    // ---- reset during WAIT; ALU result arrives afterwards ----
    alu_lat = 5;
    send_cmd(4'b0001, 8'h22, 8'h11, t);
    @(posedge CLK); #2;
    RST = 1'b1;
    @(posedge CLK); #2;
    RST = 1'b0;
    @(negedge CLK);
    check_reset_outputs("midrst");
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // ---- randomized traffic with random backpressure ----
    ready_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [3:0] f;
      logic [7:0] a, b;
      int         lat;
      f   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) f = 4'($urandom_range(0, 3));
      a   = 8'($urandom);
      b   = 8'($urandom);
      lat = $urandom_range(1, TIMEOUT + 2);
      alu_lat = lat;
      if (lat <= TIMEOUT) push_result(alu_ref(f, a, b));
      else                push_err();
      send_cmd(f, a, b, t);
    end
    ready_rand  = 1'b0;
    ready_force = 1'b1;
    wait_drain();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-level controller that sequences the team's registered ALU. Accepts one operation at a time (function code plus two operands) over a valid/ready command channel and drives the ALU operand, function and enable inputs. Waits for the ALU's output-valid flag, with a timeout, and returns the wide result serialized over a byte-wide valid/ready response channel. Sits between the system controller / UART command parser and the ALU.

Parameters:
DATA_W, 8, operand and response byte width; must equal the ALU input width
OUT_W, 16, ALU result width; must be an integer multiple of DATA_W
TIMEOUT, 8, max WAIT cycles for alu_out_valid before error; legal range 2..255

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_fun  in  4  ALU function code: [3:2] unit select, [1:0] op
cmd_a  in  DATA_W  operand A (signed)
cmd_b  in  DATA_W  operand B (signed)
alu_a  out  DATA_W  to ALU A
alu_b  out  DATA_W  to ALU B
alu_fun  out  4  to ALU function select
alu_en  out  1  ALU enable; one-cycle pulse per command
alu_out  in  OUT_W  ALU result
alu_out_valid  in  1  ALU result valid flag
rsp_valid  out  1  response byte present
rsp_ready  in  1  consumer accepts byte
rsp_data  out  DATA_W  response byte
rsp_last  out  1  final byte of this response
rsp_err  out  1  response is a timeout error
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: RST is sampled on CLK and overrides everything. State becomes IDLE and all registers clear. Outputs after reset: cmd_ready=1, alu_en=0, alu_a/alu_b/alu_fun=0, rsp_valid=0, rsp_data=0, rsp_last=0, rsp_err=0, busy=0.
- Reset mid-operation: an in-flight command is discarded and no response is produced. A late alu_out_valid arriving after reset is ignored because the sequencer is in IDLE.
- States: IDLE, ISSUE, WAIT, SEND, ERR.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, register cmd_fun, cmd_a and cmd_b, then go to ISSUE.
- ISSUE: lasts exactly one cycle. alu_en=1 and alu_a/alu_b/alu_fun are driven from the registers. Clear the timeout counter and go to WAIT.
- alu_a/alu_b/alu_fun hold their values from ISSUE until the next command is accepted.
- WAIT: alu_en=0. alu_out_valid is sampled only in this state.
  - On alu_out_valid=1, capture alu_out into the result register, set byte index=0, go to SEND.
  - Otherwise increment the counter. When counter==TIMEOUT-1 and alu_out_valid is still 0, go to ERR.
  - If alu_out_valid arrives in the same cycle the counter hits TIMEOUT-1, success wins.
- SEND: sends NB=OUT_W/DATA_W bytes, least-significant byte first.
  - rsp_valid=1 and rsp_data=result[idx*DATA_W +: DATA_W].
  - rsp_last=1 when idx==NB-1.
  - rsp_data and rsp_last are held stable while rsp_valid&&!rsp_ready.
  - On rsp_valid&&rsp_ready: idx++. On the last byte, go to IDLE.
- ERR: one byte with rsp_valid=1, rsp_data=0xFF (all ones), rsp_err=1, rsp_last=1. Held until rsp_ready, then go to IDLE.
- rsp_err=0 in SEND.
- Latency with a 1-cycle ALU: command accepted at cycle T, alu_en at T+1, alu_out_valid at T+2, first rsp_valid at T+3. With rsp_ready tied high, cmd_ready returns at T+3+NB.
- cmd_valid outside IDLE: not accepted (cmd_ready=0), and the command is not lost. The source holds it.
- Result arithmetic: no width manipulation. alu_out is passed through bit-exact, including the sign bits of negative arith results.

Decomposition:
- Package alu_seq_pkg holds:
  - the state encoding enum;
  - ALU_FUN constants: unit select ARITH=2'b00, LOGIC=2'b01, CMP=2'b10, SHIFT=2'b11; op codes (e.g. ADD=4'b0000, SUB=4'b0001, MUL=4'b0010, DIV=4'b0011);
  - the error byte value.
- One sub-module, alu_rsp_serializer: loads an OUT_W word (or an error flag) and emits DATA_W bytes with valid/ready/last. The FSM stays in the top module.

Test Plan:
Bench ALU model has 1-cycle latency unless stated.
- ADD: cmd_fun=0000, a=0x05, b=0x03, rsp_ready=1 -> alu_en one pulse at T+1; bytes 0x08 (last=0), 0x00 (last=1); rsp_err=0.
- MUL sign: cmd_fun=0010, a=0x7F, b=0x02 -> bytes 0xFE, 0x00. SUB 0x03-0x05 -> bytes 0xFE, 0xFF.
- Backpressure: hold rsp_ready=0 for 5 cycles during byte 0 -> rsp_data=0x08 stable and rsp_valid high throughout; no byte skipped; cmd_ready=0 until the last byte is accepted.
- Busy blocking: assert a second cmd_valid (a=0x10) during WAIT -> not accepted. Accepted the cycle after return to IDLE; its response follows the first one intact.
- Timeout: bench ALU never asserts valid, TIMEOUT=8 -> 8 WAIT cycles, then one byte 0xFF with rsp_err=1, rsp_last=1; then IDLE.
- Timeout boundary: valid arrives in the last WAIT cycle -> normal result response, no error.
- Reset mid-op: RST=1 for one cycle during WAIT, bench asserts alu_out_valid afterwards -> no rsp_valid; cmd_ready=1 the cycle after reset; all outputs at reset values.
